// File: rtl/skolem_uge_urem1_checker.sv
// Sequential witness checker for bvuge/bvurem1: computes s urem x with a W-step
// restoring divider, then checks (s urem x) >=u t against the condition t <=u s.
module skolem_uge_urem1_checker #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  t,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_rem,
  output logic [W-1:0]  out_quo,
  output logic          out_sat,
  output logic          out_ic,
  output logic          out_err,
  output logic [CW-1:0] chk_cnt,
  output logic [CW-1:0] err_cnt
);
  localparam int SW = $clog2(W);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [W:0]    r, r_sh, r_nx;
  logic [W-1:0]  q, q_nx, s_q, t_q, x_q;
  logic [SW-1:0] step;
  logic          ge, last, fin_sat, fin_ic;

  // One restoring step; x=0 always subtracts zero, giving rem=s and quo=all-ones.
  always_comb begin
    r_sh    = {r[W-1:0], q[W-1]};
    ge      = r_sh >= {1'b0, x_q};
    r_nx    = ge ? r_sh - {1'b0, x_q} : r_sh;
    q_nx    = {q[W-2:0], ge};
    last    = step == SW'(W-1);
    fin_sat = r_nx[W-1:0] >= t_q;
    fin_ic  = t_q <= s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = DIV;
      end
      DIV:  if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r       <= '0;
      q       <= '0;
      s_q     <= '0;
      t_q     <= '0;
      x_q     <= '0;
      step    <= '0;
      out_sat <= 1'b0;
      out_ic  <= 1'b0;
      out_err <= 1'b0;
      chk_cnt <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s_q  <= s;
          t_q  <= t;
          x_q  <= x;
          r    <= '0;
          q    <= s;
          step <= '0;
        end
        DIV: begin
          r    <= r_nx;
          q    <= q_nx;
          step <= step + 1'b1;
          if (last) begin
            out_sat <= fin_sat;
            out_ic  <= fin_ic;
            out_err <= fin_ic & ~fin_sat;
            if (chk_cnt != '1) chk_cnt <= chk_cnt + 1'b1;
            if (fin_ic && !fin_sat && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_rem = r[W-1:0];
  assign out_quo = q;
endmodule

// File: tb/tb_skolem_uge_urem1_checker.sv
// Bench for skolem_uge_urem1_checker: directed scenarios plus randomized-handshake
// sweeps against an arithmetic reference model.
module tb_skolem_uge_urem1_checker;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  s = '0, t = '0, x = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_rem, out_quo;
  logic          out_sat, out_ic, out_err;
  logic [CW-1:0] chk_cnt, err_cnt;

  skolem_uge_urem1_checker #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .out_rem(out_rem), .out_quo(out_quo), .out_sat(out_sat), .out_ic(out_ic),
    .out_err(out_err), .chk_cnt(chk_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rem, quo, sat, ic, err, chk, errc, lat;
    logic acc_ready;
  } res_t;

  int n_cmp = 0, n_bad = 0;
  int exp_chk = 0, exp_err = 0;

  // Reference: SMT-LIB urem/udiv with x=0 giving rem=s, quo=all-ones.
  function automatic int m_rem(int sv, int xv);
    return (xv == 0) ? sv : sv % xv;
  endfunction
  function automatic int m_quo(int sv, int xv);
    return (xv == 0) ? (1 << W) - 1 : sv / xv;
  endfunction
  function automatic int m_err(int sv, int tv, int xv);
    return (tv <= sv && m_rem(sv, xv) < tv) ? 1 : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_chk = 0; exp_err = 0;
  endtask

  // Runs one transaction and returns what the DUT showed; callers compare.
  task automatic xact(input int si, input int ti, input int xi, input int stall, output res_t o);
    @(negedge clk);
    s = W'(si); t = W'(ti); x = W'(xi); in_valid = 1'b1;
    o.acc_ready = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    s = W'($urandom); t = W'($urandom); x = W'($urandom);
    o.lat = 0;
    while (!out_valid && o.lat < 4 * W + 8) begin
      @(negedge clk);
      o.lat++;
    end
    o.rem = int'(out_rem); o.quo = int'(out_quo);
    o.sat = int'(out_sat); o.ic = int'(out_ic); o.err = int'(out_err);
    o.chk = int'(chk_cnt); o.errc = int'(err_cnt);
    if (exp_chk != MAXC) exp_chk++;
    if (m_err(si, ti, xi) == 1 && exp_err != MAXC) exp_err++;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({in_ready, out_valid, out_rem, out_quo, out_sat, out_ic, out_err, chk_cnt, err_cnt} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 3'b000, {CW{1'b0}}, {CW{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset: got rdy=%0b vld=%0b rem=%0d quo=%0d sat=%0b ic=%0b err=%0b chk=%0d errc=%0d, need 1 0 0 0 0 0 0 0 0",
               in_ready, out_valid, out_rem, out_quo, out_sat, out_ic, out_err, chk_cnt, err_cnt);
    end
  endtask

  task automatic test_directed(input string nm, input int si, input int ti, input int xi,
                               input int rem, input int quo, input int sat, input int ic, input int err);
    res_t o;
    xact(si, ti, xi, 0, o);
    n_cmp++;
    if (o.lat !== W) begin n_bad++; $display("FAIL %s latency: got %0d need %0d", nm, o.lat, W); end
    n_cmp++;
    if ({o.rem, o.quo, o.sat, o.ic, o.err} !== {rem, quo, sat, ic, err}) begin
      n_bad++;
      $display("FAIL %s result: got rem=%0d quo=%0d sat=%0d ic=%0d err=%0d need %0d %0d %0d %0d %0d",
               nm, o.rem, o.quo, o.sat, o.ic, o.err, rem, quo, sat, ic, err);
    end
    n_cmp++;
    if (o.chk !== exp_chk || o.errc !== exp_err) begin
      n_bad++;
      $display("FAIL %s counters: got chk=%0d err=%0d need %0d %0d", nm, o.chk, o.errc, exp_chk, exp_err);
    end
  endtask

  task automatic test_backpressure();
    int lat = 0;
    @(negedge clk);
    s = 4'd13; x = 4'd4; t = 4'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 4 * W + 8) begin @(negedge clk); lat++; end
    if (exp_chk != MAXC) exp_chk++;
    s = 4'd7; x = 4'd3; t = 4'd2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, out_rem, out_quo, out_sat, out_ic, out_err} !==
          {1'b1, 1'b0, 4'd1, 4'd3, 3'b110} || int'(chk_cnt) !== exp_chk) begin
        n_bad++;
        $display("FAIL backpressure hold %0d: got vld=%0b rdy=%0b rem=%0d quo=%0d sat=%0b ic=%0b err=%0b chk=%0d need 1 0 1 3 1 1 0 %0d",
                 i, out_valid, in_ready, out_rem, out_quo, out_sat, out_ic, out_err, chk_cnt, exp_chk);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure release: got vld=%0b rdy=%0b need 0 1", out_valid, in_ready);
    end
    repeat (W + 3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || int'(chk_cnt) !== exp_chk) begin
      n_bad++;
      $display("FAIL backpressure no_queue: got vld=%0b chk=%0d need 0 %0d", out_valid, chk_cnt, exp_chk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    s = 4'd13; x = 4'd4; t = 4'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_rem, out_quo, out_sat, out_ic, out_err, chk_cnt, err_cnt} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 3'b000, {CW{1'b0}}, {CW{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_mid: got rdy=%0b vld=%0b rem=%0d quo=%0d sat=%0b ic=%0b err=%0b chk=%0d errc=%0d, need 1 0 0 0 0 0 0 0 0",
               in_ready, out_valid, out_rem, out_quo, out_sat, out_ic, out_err, chk_cnt, err_cnt);
    end
    rst = 1'b0;
    exp_chk = 0; exp_err = 0;
  endtask

  // x from a Skolem witness for s urem x >=u t: x=0, or x=s+1 when that fits.
  task automatic test_skolem_sweep();
    res_t o;
    int xi, errs = 0;
    do_reset();
    for (int si = 0; si < 16; si++)
      for (int ti = 0; ti < 16; ti++) begin
        xi = (si == 15 || $urandom_range(0, 1) == 0) ? 0 : si + 1;
        xact(si, ti, xi, $urandom_range(0, 1), o);
        if (o.err != 0 || o.lat != W) errs++;
      end
    n_cmp++;
    if (errs !== 0) begin n_bad++; $display("FAIL skolem_err: got %0d bad checks need 0", errs); end
    n_cmp++;
    if (int'(chk_cnt) !== MAXC || int'(err_cnt) !== 0) begin
      n_bad++;
      $display("FAIL skolem_counters: got chk=%0d err=%0d need %0d 0", chk_cnt, err_cnt, MAXC);
    end
  endtask

  task automatic test_full_sweep();
    res_t o;
    int bad = 0;
    do_reset();
    for (int si = 0; si < 16; si++)
      for (int ti = 0; ti < 16; ti++)
        for (int xi = 0; xi < 16; xi++) begin
          xact(si, ti, xi, $urandom_range(0, 2), o);
          n_cmp++;
          if (o.lat !== W || o.rem !== m_rem(si, xi) || o.quo !== m_quo(si, xi) ||
              o.sat !== int'(m_rem(si, xi) >= ti) || o.ic !== int'(ti <= si) ||
              o.err !== m_err(si, ti, xi) || o.chk !== exp_chk || o.errc !== exp_err) begin
            n_bad++; bad++;
            if (bad <= 10)
              $display("FAIL sweep s=%0d t=%0d x=%0d: got lat=%0d rem=%0d quo=%0d sat=%0d ic=%0d err=%0d chk=%0d errc=%0d need %0d %0d %0d %0d %0d %0d %0d %0d",
                       si, ti, xi, o.lat, o.rem, o.quo, o.sat, o.ic, o.err, o.chk, o.errc,
                       W, m_rem(si, xi), m_quo(si, xi), int'(m_rem(si, xi) >= ti), int'(ti <= si),
                       m_err(si, ti, xi), exp_chk, exp_err);
          end
        end
  endtask

  task automatic test_back_to_back();
    res_t o;
    int si, ti, xi;
    for (int i = 0; i < 8; i++) begin
      si = $urandom_range(0, 15); ti = $urandom_range(0, 15); xi = $urandom_range(0, 15);
      xact(si, ti, xi, 0, o);
      n_cmp++;
      if (o.acc_ready !== 1'b1 || in_ready !== 1'b1 || o.rem !== m_rem(si, xi)) begin
        n_bad++;
        $display("FAIL back_to_back %0d: got acc_rdy=%0b rdy=%0b rem=%0d need 1 1 %0d",
                 i, o.acc_ready, in_ready, o.rem, m_rem(si, xi));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("basic",      13, 1, 4, 1, 3, 1, 1, 0);
    test_directed("zero_div",    5, 5, 0, 5, 15, 1, 1, 0);
    test_directed("wrong",      13, 4, 5, 3, 2, 0, 1, 1);
    test_directed("cond_false",  3, 9, 2, 1, 1, 0, 0, 0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_skolem_sweep();
    test_full_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
